output_port_arbiter: RTL



---
 rtl/output_port_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/output_port_arbiter.sv
// Output-port arbiter: round-robin over four path-computation requesters,
// buffering accepted packets (with source ID and input index) in a small FIFO.
module output_port_arbiter #(
    parameter int WIDTH = 11,
    parameter int ID_W  = 3,
    parameter int N_IN  = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [N_IN*ID_W-1:0]   in_id,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_src_id,
    output logic [1:0]             out_in_idx,
    output logic [CNT_W-1:0]       fwd_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = WIDTH + ID_W + 2;
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       rr_ptr;
    logic [1:0]       grant;
    logic [1:0]       cand;
    logic             grant_found;
    logic             full;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Scan the requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        grant       = 2'd0;
        grant_found = 1'b0;
        cand        = 2'd0;
        for (int k = 0; k < N_IN; k++) begin
            cand = rr_ptr + 2'(k);
            if (!grant_found && in_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    assign full      = (fifo_level == FULL_LVL);
    assign push      = rst_n & grant_found & ~full;
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid & out_ready;

    always_comb begin
        in_ready = '0;
        if (push) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign head       = mem[rd_ptr];
    assign out_data   = head[ENT_W-1 -: WIDTH];
    assign out_src_id = head[2 +: ID_W];
    assign out_in_idx = head[1:0];

    // Storage is cleared on reset so the head reads zero and no stale packet survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rr_ptr     <= 2'd0;
            fifo_level <= '0;
            fwd_count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_data[int'(grant)*WIDTH +: WIDTH],
                                in_id[int'(grant)*ID_W +: ID_W], grant};
                wr_ptr      <= wr_ptr + 1'b1;
                rr_ptr      <= grant + 2'd1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                fwd_count <= fwd_count + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule
